// File: rtl/elbeth_bus_arbiter.sv
// ---------------------------------------------------------------------------
// elbeth_bus_arbiter
//
// Round-robin arbiter sharing one 32-bit slave port between four masters.
// It owns the 2-bit select of the 4-to-1 datapath mux, runs one transfer per
// grant, waits for the slave acknowledge (or a timeout), and returns a
// one-cycle completion pulse to the owning master.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_req[3:0]   level request per master (bit i = master i)
//   i_slave_ack  slave completes the current transfer (sampled in BUSY only)
//   o_grant      one-hot grant to the owner, 0 when there is no owner
//   o_bit_select binary index of the (last) owner, drives the mux select
//   o_bus_valid  high while a granted transfer is in progress
//   o_done       one-cycle completion pulse to the owner
//   o_bus_error  one-cycle pulse when a transfer is released by timeout
//   o_busy       high in any state other than IDLE
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module elbeth_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_req,
  input  logic       i_slave_ack,
  output logic [3:0] o_grant,
  output logic [1:0] o_bit_select,
  output logic       o_bus_valid,
  output logic [3:0] o_done,
  output logic       o_bus_error,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t              r_state, w_state_next;
  logic [1:0]          r_ptr, w_ptr_next;
  logic [TO_WIDTH-1:0] r_cnt, w_cnt_next;
  logic [3:0]          r_grant, w_grant_next;
  logic [1:0]          r_sel, w_sel_next;
  logic                r_valid, w_valid_next;
  logic [3:0]          r_done, w_done_next;
  logic                r_err, w_err_next;
  logic                r_busy, w_busy_next;

  // Requests rotated so that position 0 is the current highest-priority
  // master; the 2-bit add wraps naturally modulo 4.
  logic [1:0] w_rot_idx [4];
  logic [3:0] w_rot_req;
  logic [1:0] w_pick;
  logic       w_timeout;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign w_rot_idx[gi] = r_ptr + 2'(gi);
      assign w_rot_req[gi] = i_req[w_rot_idx[gi]];
    end
  endgenerate

  // First set bit in rotated order; scanning from the far end down leaves
  // the lowest rotated position as the winner.
  always_comb begin
    w_pick = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (w_rot_req[k]) begin
        w_pick = w_rot_idx[k];
      end
    end
  end

  // Counter is 0 on the first BUSY edge, so TIMEOUT_CYCLES-1 is the last one.
  assign w_timeout = (r_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_cnt_next   = r_cnt;
    w_grant_next = r_grant;
    w_sel_next   = r_sel;
    w_valid_next = r_valid;
    w_done_next  = 4'b0000;
    w_err_next   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (|i_req) begin
          w_state_next = S_BUSY;
          w_grant_next = 4'b0001 << w_pick;
          w_sel_next   = w_pick;
          w_valid_next = 1'b1;
          w_cnt_next   = '0;
        end
      end
      S_BUSY: begin
        w_cnt_next = r_cnt + 1'b1;
        if (i_slave_ack || w_timeout) begin
          w_state_next = S_RELEASE;
          w_done_next  = r_grant;
          // An ack on the timeout edge still counts as success.
          w_err_next   = ~i_slave_ack;
          w_grant_next = 4'b0000;
          w_valid_next = 1'b0;
          w_ptr_next   = r_sel + 2'd1;
        end
      end
      S_RELEASE: begin
        // Requests are not looked at here, giving the owner an edge to
        // drop req after seeing done.
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_cnt   <= '0;
      r_grant <= 4'b0000;
      r_sel   <= 2'd0;
      r_valid <= 1'b0;
      r_done  <= 4'b0000;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_cnt   <= w_cnt_next;
      r_grant <= w_grant_next;
      r_sel   <= w_sel_next;
      r_valid <= w_valid_next;
      r_done  <= w_done_next;
      r_err   <= w_err_next;
      r_busy  <= w_busy_next;
    end
  end

  assign o_grant      = r_grant;
  assign o_bit_select = r_sel;
  assign o_bus_valid  = r_valid;
  assign o_done       = r_done;
  assign o_bus_error  = r_err;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_elbeth_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_elbeth_bus_arbiter
//
// Bench for elbeth_bus_arbiter (built with TIMEOUT_CYCLES=4): a directed
// vector table, hand-written fairness / reset sequences, and a randomized
// run checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_elbeth_bus_arbiter;

  localparam int TO = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       slave_ack;
  logic [3:0] grant;
  logic [1:0] bit_select;
  logic       bus_valid;
  logic [3:0] done;
  logic       bus_error;
  logic       busy;

  int vectors;
  int miscompares;

  elbeth_bus_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .TO_WIDTH(8)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req(req),
    .i_slave_ack(slave_ack),
    .o_grant(grant),
    .o_bit_select(bit_select),
    .o_bus_valid(bus_valid),
    .o_done(done),
    .o_bus_error(bus_error),
    .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed output view: {grant, sel, valid, done, err, busy}
  function automatic logic [12:0] pack(input logic [3:0] g, input logic [1:0] s,
                                       input logic v, input logic [3:0] d,
                                       input logic e, input logic b);
    return {g, s, v, d, e, b};
  endfunction

  task automatic check(input string name, input logic [12:0] exp);
    logic [12:0] got;
    got = pack(grant, bit_select, bus_valid, done, bus_error, busy);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got g=%b s=%0d v=%b d=%b e=%b b=%b exp g=%b s=%0d v=%b d=%b e=%b b=%b",
               name, got[12:9], got[8:7], got[6], got[5:2], got[1], got[0],
               exp[12:9], exp[8:7], exp[6], exp[5:2], exp[1], exp[0]);
    end else begin
      $display("ok   %s g=%b s=%0d v=%b d=%b e=%b b=%b", name,
               got[12:9], got[8:7], got[6], got[5:2], got[1], got[0]);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end else begin
      $display("ok   %s value=%0d", name, got);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = 4'b0000;
    slave_ack = 1'b0;
    repeat (2) step();
    check("reset", 13'd0);
    rst_n = 1'b1;
  endtask

  // ---------------- reference model (transaction level) ----------------
  int         m_owner;     // -1 when no transfer in progress
  bit         m_releasing; // completion cycle in progress
  int         m_elapsed;   // BUSY edges already spent on this transfer
  int         m_ptr;
  int         m_last;
  logic [3:0] m_done;
  logic       m_err;

  task automatic model_reset();
    m_owner = -1; m_releasing = 0; m_elapsed = 0; m_ptr = 0; m_last = 0;
    m_done = 4'b0; m_err = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic a);
    m_done = 4'b0;
    m_err  = 1'b0;
    if (m_releasing) begin
      m_releasing = 0;
    end else if (m_owner >= 0) begin
      if (a || m_elapsed == TO - 1) begin
        m_done      = 4'(1 << m_owner);
        m_err       = !a;
        m_ptr       = (m_owner + 1) % 4;
        m_owner     = -1;
        m_releasing = 1;
      end else begin
        m_elapsed++;
      end
    end else if (r != 4'b0) begin
      for (int k = 0; k < 4; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
      end
      m_last    = m_owner;
      m_elapsed = 0;
    end
  endtask

  function automatic logic [12:0] model_out();
    logic [3:0] g;
    g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
    return pack(g, 2'(m_last), m_owner >= 0, m_done, m_err,
                (m_owner >= 0) || m_releasing);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0]  req;
    logic        ack;
    logic [12:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[23];

  initial begin
    int   order_cnt;
    int   last_cyc;
    int   exp_idx;
    logic [3:0] r_cur;

    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    req = 4'b0;
    slave_ack = 1'b0;

    //          req      ack  g        s     v     d        e     b
    tbl[0]  = '{4'b0100, 1'b0, pack(4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b1), "single_grant"};
    tbl[1]  = '{4'b0100, 1'b0, pack(4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b1), "single_hold1"};
    tbl[2]  = '{4'b0100, 1'b0, pack(4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b1), "single_hold2"};
    tbl[3]  = '{4'b0100, 1'b1, pack(4'b0000, 2'd2, 1'b0, 4'b0100, 1'b0, 1'b1), "single_done"};
    tbl[4]  = '{4'b0000, 1'b0, pack(4'b0000, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b0), "single_idle"};
    tbl[5]  = '{4'b1001, 1'b0, pack(4'b1000, 2'd3, 1'b1, 4'b0000, 1'b0, 1'b1), "ptr3_grant3"};
    tbl[6]  = '{4'b1001, 1'b1, pack(4'b0000, 2'd3, 1'b0, 4'b1000, 1'b0, 1'b1), "m3_done"};
    tbl[7]  = '{4'b1001, 1'b0, pack(4'b0000, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b0), "release_noreq"};
    tbl[8]  = '{4'b1001, 1'b0, pack(4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b1), "wrap_grant0"};
    tbl[9]  = '{4'b1001, 1'b1, pack(4'b0000, 2'd0, 1'b0, 4'b0001, 1'b0, 1'b1), "m0_done"};
    tbl[10] = '{4'b1000, 1'b0, pack(4'b0000, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0), "idle2"};
    tbl[11] = '{4'b1000, 1'b0, pack(4'b1000, 2'd3, 1'b1, 4'b0000, 1'b0, 1'b1), "to_grant3"};
    tbl[12] = '{4'b1000, 1'b0, pack(4'b1000, 2'd3, 1'b1, 4'b0000, 1'b0, 1'b1), "to_busy1"};
    tbl[13] = '{4'b0000, 1'b0, pack(4'b1000, 2'd3, 1'b1, 4'b0000, 1'b0, 1'b1), "to_busy2_reqdrop"};
    tbl[14] = '{4'b1000, 1'b0, pack(4'b1000, 2'd3, 1'b1, 4'b0000, 1'b0, 1'b1), "to_busy3"};
    tbl[15] = '{4'b1000, 1'b0, pack(4'b0000, 2'd3, 1'b0, 4'b1000, 1'b1, 1'b1), "timeout"};
    tbl[16] = '{4'b0000, 1'b0, pack(4'b0000, 2'd3, 1'b0, 4'b0000, 1'b0, 1'b0), "to_idle"};
    tbl[17] = '{4'b0010, 1'b0, pack(4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b1), "coin_grant1"};
    tbl[18] = '{4'b0010, 1'b0, pack(4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b1), "coin_busy1"};
    tbl[19] = '{4'b0010, 1'b0, pack(4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b1), "coin_busy2"};
    tbl[20] = '{4'b0010, 1'b0, pack(4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b1), "coin_busy3"};
    tbl[21] = '{4'b0010, 1'b1, pack(4'b0000, 2'd1, 1'b0, 4'b0010, 1'b0, 1'b1), "ack_at_timeout"};
    tbl[22] = '{4'b0000, 1'b0, pack(4'b0000, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b0), "coin_idle"};

    do_reset();
    for (int i = 0; i < 23; i++) begin
      req       = tbl[i].req;
      slave_ack = tbl[i].ack;
      step();
      check(tbl[i].name, tbl[i].exp);
    end

    // ---- fairness: all four request, ack every cycle, drop req on done ----
    do_reset();
    r_cur = 4'b1111;
    req = r_cur;
    slave_ack = 1'b1;
    order_cnt = 0;
    last_cyc = -1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (grant != 4'b0) begin
        exp_idx = order_cnt % 4;
        check_int("fair_order", int'(bit_select), exp_idx);
        if (last_cyc >= 0) check_int("fair_spacing", c - last_cyc, 3);
        last_cyc = c;
        order_cnt++;
      end
      if (done != 4'b0) begin
        r_cur = r_cur & ~done;
        req = r_cur;
      end
    end
    check_int("fair_count", order_cnt, 4);
    slave_ack = 1'b0;
    req = 4'b1111;
    step();
    check("fair_ptr_back_to0", pack(4'b0001, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b1));

    // ---- async reset in the middle of master 2's transfer ----
    do_reset();
    req = 4'b0100;
    step();
    check("ar_grant2", pack(4'b0100, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b1));
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_immediate", 13'd0);
    req = 4'b0110;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ar_ptr0_grant1", pack(4'b0010, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b1));

    // ---- randomized run against the reference model ----
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      logic [3:0] r;
      logic a;
      r = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      a = ($urandom_range(0, 3) == 0);
      req = r;
      slave_ack = a;
      step();
      model_edge(r, a);
      check($sformatf("rand%0d req=%b ack=%b", c, r, a), model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/elbeth_bus_arbiter.md
Name: elbeth_bus_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit slave port between four masters.
- Drives the 2-bit select of the team's 4-to-1 datapath mux (elbeth_mux_4_to_1) so only the granted master's word reaches the slave.
- Sequences one transfer per grant, waits for the slave's acknowledge, enforces a timeout, and returns a completion pulse to the owner.

Parameters:
- TIMEOUT_CYCLES, 255, number of BUSY cycles without slave_ack before forced release; legal range 2..2^TO_WIDTH-1.
- TO_WIDTH, 8, width of the internal timeout counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  level request per master; bit i = master i; held high until done[i].
- slave_ack  input  1  slave completes the current transfer (single-cycle or level, sampled only in BUSY).
- grant  output  4  one-hot grant to the owning master; 0 when no owner.
- bit_select  output  2  select for the 4-to-1 mux; binary index of the owner.
- bus_valid  output  1  high while a granted transfer is in progress.
- done  output  4  one-cycle completion pulse to the owner (success or timeout).
- bus_error  output  1  one-cycle pulse when a transfer is released by timeout.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Async reset (rst_n low, any time, including mid-transfer):
  - grant=0, bit_select=2'b00, bus_valid=0, done=0, bus_error=0, busy=0.
  - State=IDLE, priority pointer ptr=0, timeout counter=0.
  - Outputs reach reset values immediately, without waiting for clk.
- All outputs are registered; there is no combinational path from inputs to outputs.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - Stay here while req==0; slave_ack is ignored.
  - When req!=0 at an edge, search from index ptr upward (mod 4) and select the first set bit g.
  - On that edge: state->BUSY, grant=1<<g, bit_select=g, bus_valid=1, busy=1, counter=0.
  - Latency: req sampled at edge N gives grant and bus_valid visible after edge N, i.e. one cycle.
- BUSY:
  - grant, bit_select and bus_valid are held stable. Changes on req, including the owner dropping its req, are ignored.
  - Counter increments every cycle.
  - slave_ack=1 at an edge: state->RELEASE, done[g]=1, grant=0, bus_valid=0, ptr=(g+1) mod 4.
  - No ack and counter==TIMEOUT_CYCLES-1 at an edge: same as the ack case, and bus_error=1 as well.
  - Ack and timeout on the same edge: the ack wins, bus_error stays 0.
- RELEASE:
  - Exactly one cycle; done/bus_error are high only during this cycle.
  - Next edge: done=0, bus_error=0, state->IDLE, busy=0.
  - req is not sampled here. This gives the owner one edge to drop req after seeing done.
  - The earliest re-grant is therefore 2 edges after the ack edge.
- bit_select keeps the last owner's index in IDLE/RELEASE so the mux output does not toggle needlessly. Only grant and bus_valid qualify the select.
- Pointer wrap: owner 3 sets ptr to 0.
- Fairness: with all requesters continuously active, service order is 0,1,2,3,0,... Any active requester waits at most 3 other transfers.
- Masters must keep req high until done. A master that re-asserts req after done re-enters arbitration at its new round-robin priority.
- No X on outputs after reset. Undefined req bits are not a legal input.

Test Plan:
- Single requester: reset, req=4'b0100 at edge 2, ack 3 cycles later.
  - grant=0100, bit_select=2, bus_valid=1 from edge 2.
  - done=0100 for one cycle after the ack edge; bus_error never set.
- All four requesting, slave acks every BUSY cycle and each master drops req on done.
  - Grant order is 0,1,2,3; ptr returns to 0.
  - Each transfer occupies 3 cycles (BUSY, RELEASE, IDLE).
- Pointer wrap with req=4'b1001 held after a master-3 transfer: next grant is master 0 (bit_select=0), not master 3.
- Timeout with TIMEOUT_CYCLES=4, req=4'b0010, no ack:
  - After 4 BUSY cycles, bus_error=1 and done=0010 for one cycle.
  - grant=0, then IDLE.
- Ack coincident with timeout: ack asserted on the 4th BUSY cycle gives done pulse with bus_error=0.
- Async reset mid-BUSY: drop rst_n between clock edges during master 2's transfer.
  - All outputs go to reset values before the next edge; ptr=0.
  - After release, req=4'b0110 grants master 1 first.
